// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter sharing one external 6-bit adder among NREQ requesters.
// Ports: clk/rst_n (sync active-low), req_valid/req_ready/req_x/req_y request
//   side, adder_x/adder_y/adder_s to the shared adder, resp_valid/resp_ready/
//   resp_sum/resp_id response side, busy status and saturating done_cnt.
module adder_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*6-1:0] req_x,
  input  logic [NREQ*6-1:0] req_y,
  output logic [5:0]        adder_x,
  output logic [5:0]        adder_y,
  input  logic [6:0]        adder_s,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [6:0]        resp_sum,
  output logic [IDW-1:0]    resp_id,
  output logic              busy,
  output logic [CNTW-1:0]   done_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    RESP
  } state_t;

  state_t         state;
  logic [IDW-1:0] last;
  logic [IDW-1:0] id_reg;
  logic [IDW-1:0] sel;
  logic           found;
  int             idx;

  // First valid requester at or after last+1, wrapping at NREQ.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        sel   = IDW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && found)
      req_ready[sel] = 1'b1;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last       <= IDW'(NREQ - 1);
      id_reg     <= '0;
      adder_x    <= '0;
      adder_y    <= '0;
      resp_valid <= 1'b0;
      resp_sum   <= '0;
      resp_id    <= '0;
      done_cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            adder_x <= req_x[int'(sel)*6 +: 6];
            adder_y <= req_y[int'(sel)*6 +: 6];
            id_reg  <= sel;
            last    <= sel;
            state   <= ADD;
          end
        end
        ADD: begin
          resp_sum   <= adder_s;
          resp_id    <= id_reg;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            if (done_cnt != {CNTW{1'b1}})
              done_cnt <= done_cnt + 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed bench for adder_rr_arbiter.
// Table of single transactions plus hand-written multi-cycle sequences.
module tb_adder_rr_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int CNTW = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*6-1:0] req_x;
  logic [NREQ*6-1:0] req_y;
  logic [5:0]        adder_x;
  logic [5:0]        adder_y;
  logic [6:0]        adder_s;
  logic              resp_valid;
  logic              resp_ready;
  logic [6:0]        resp_sum;
  logic [IDW-1:0]    resp_id;
  logic              busy;
  logic [CNTW-1:0]   done_cnt;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  // The shared adder lives outside the arbiter.
  assign adder_s = {1'b0, adder_x} + {1'b0, adder_y};

  adder_rr_arbiter #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .adder_x    (adder_x),
    .adder_y    (adder_y),
    .adder_s    (adder_s),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_sum   (resp_sum),
    .resp_id    (resp_id),
    .busy       (busy),
    .done_cnt   (done_cnt)
  );

  typedef struct {
    int id;
    int x;
    int y;
    int sum;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_op(input int i, input int x, input int y);
    req_x[i*6 +: 6] = 6'(x);
    req_y[i*6 +: 6] = 6'(y);
  endtask

  task automatic txn(input int id, input int x, input int y,
                     input int sum);
    set_op(id, x, y);
    req_valid = '0;
    req_valid[id] = 1'b1;
    #1;
    chk("grant", int'(req_ready), 1 << id);
    tick();
    req_valid = '0;
    chk("add_x", int'(adder_x), x);
    chk("add_y", int'(adder_y), y);
    chk("add_busy", int'(busy), 1);
    chk("add_rv", int'(resp_valid), 0);
    tick();
    chk("rv", int'(resp_valid), 1);
    chk("sum", int'(resp_sum), sum);
    chk("id", int'(resp_id), id);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    exp_cnt++;
    chk("rv_clr", int'(resp_valid), 0);
    chk("idle_busy", int'(busy), 0);
    chk("cnt", int'(done_cnt), exp_cnt);
  endtask

  initial begin
    int ex[4];
    int ey[4];
    int es[4];
    int order[6];

    vecs[0] = '{0, 5, 9, 14};
    vecs[1] = '{2, 63, 63, 126};
    vecs[2] = '{3, 0, 0, 0};
    vecs[3] = '{1, 32, 31, 63};
    vecs[4] = '{1, 63, 1, 64};
    ex = '{10, 20, 40, 60};
    ey = '{1, 2, 30, 50};
    es = '{11, 22, 70, 110};
    order = '{0, 1, 2, 3, 0, 1};

    rst_n = 1'b0;
    req_valid = '0;
    req_x = '0;
    req_y = '0;
    resp_ready = 1'b0;
    tick();
    tick();
    chk("rst_rv", int'(resp_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cnt", int'(done_cnt), 0);
    chk("rst_sum", int'(resp_sum), 0);
    chk("rst_ax", int'(adder_x), 0);
    chk("rst_rdy", int'(req_ready), 0);
    rst_n = 1'b1;
    tick();

    // Single transactions
    foreach (vecs[i])
      txn(vecs[i].id, vecs[i].x, vecs[i].y, vecs[i].sum);

    // All requesters valid: rotation 0,1,2,3,0,1 after last grant to 1
    // starts at 2, so first re-sync the pointer to requester 3.
    txn(3, 1, 1, 2);
    for (int i = 0; i < NREQ; i++) set_op(i, ex[i], ey[i]);
    req_valid = '1;
    resp_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      #1;
      chk("rr_grant", int'(req_ready), 1 << order[n]);
      tick();
      chk("rr_rdy_add", int'(req_ready), 0);
      tick();
      chk("rr_rv", int'(resp_valid), 1);
      chk("rr_id", int'(resp_id), order[n]);
      chk("rr_sum", int'(resp_sum), es[order[n]]);
      tick();
      exp_cnt++;
    end
    req_valid = '0;
    resp_ready = 1'b0;
    chk("rr_cnt", int'(done_cnt), exp_cnt);

    // Back-pressure: hold resp_ready low 5 cycles in RESP
    set_op(2, 17, 46);
    req_valid = 4'b0100;
    tick();
    req_valid = '1;
    tick();
    for (int n = 0; n < 5; n++) begin
      chk("bp_rv", int'(resp_valid), 1);
      chk("bp_sum", int'(resp_sum), 63);
      chk("bp_id", int'(resp_id), 2);
      chk("bp_rdy", int'(req_ready), 0);
      chk("bp_busy", int'(busy), 1);
      chk("bp_cnt", int'(done_cnt), exp_cnt);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    req_valid = '0;
    exp_cnt++;
    chk("bp_cnt_done", int'(done_cnt), exp_cnt);
    chk("bp_rv_clr", int'(resp_valid), 0);

    // Pointer: grant 1, then 0101 grants 2 then 0
    txn(1, 7, 8, 15);
    set_op(0, 1, 2);
    set_op(2, 3, 4);
    req_valid = 4'b0101;
    #1;
    chk("ptr_g2", int'(req_ready), 4'b0100);
    tick();
    tick();
    chk("ptr_id2", int'(resp_id), 2);
    chk("ptr_sum2", int'(resp_sum), 7);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    exp_cnt++;
    #1;
    chk("ptr_g0", int'(req_ready), 4'b0001);
    tick();
    req_valid = '0;
    tick();
    chk("ptr_id0", int'(resp_id), 0);
    chk("ptr_sum0", int'(resp_sum), 3);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    exp_cnt++;
    chk("ptr_cnt", int'(done_cnt), exp_cnt);

    // Reset during ADD after granting requester 2
    set_op(2, 9, 9);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    chk("ra_busy", int'(busy), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("ra_rv", int'(resp_valid), 0);
    chk("ra_busy0", int'(busy), 0);
    chk("ra_cnt", int'(done_cnt), 0);
    chk("ra_ax", int'(adder_x), 0);
    chk("ra_sum", int'(resp_sum), 0);
    req_valid = '1;
    #1;
    chk("ra_grant", int'(req_ready), 4'b0001);
    tick();
    req_valid = '0;
    tick();
    chk("ra_id", int'(resp_id), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
